// File: rtl/spi_cmd_ctrl.sv
// Command-frame controller between the SPI slave byte engine and the servo
// position register bank: decodes query/write/read frames and drives tx handshake.
module spi_cmd_ctrl #(
  parameter int         N_REG       = 18,
  parameter logic [7:0] STATUS_BYTE = 8'hD4,
  parameter logic [7:0] ID_BYTE     = 8'hC4,
  parameter int         TIMEOUT     = 50000,
  parameter logic [7:0] REG_RST     = 8'h80
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ncs,
  input  logic               rx_done,
  input  logic [7:0]         rx_data,
  input  logic               tx_done,
  output logic               tx_call,
  output logic [7:0]         tx_data,
  output logic [N_REG*8-1:0] servo_pos,
  output logic               wr_strobe,
  output logic               frame_ok,
  output logic [7:0]         err_cnt,
  output logic [2:0]         o_state
);

  // Handshake: rx_done/tx_done are single-cycle pulses from the slave; rx_data is
  // valid only while rx_done is high. tx_call rises with tx_data already stable and
  // both stay unchanged until the tx_done pulse (or an abort/timeout) clears them.

  localparam int         TW       = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [7:0] N_REG_B  = 8'(N_REG);

  localparam logic [7:0] CMD_STATUS = 8'h06;
  localparam logic [7:0] CMD_ID     = 8'hAA;
  localparam logic [7:0] CMD_WRITE  = 8'h10;
  localparam logic [7:0] CMD_READ   = 8'h20;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    GET_ADDR = 3'd1,
    GET_DATA = 3'd2,
    TX_LOAD  = 3'd3,
    TX_WAIT  = 3'd4
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic            r_ncs_meta;
  logic            r_ncs_sync;
  logic            r_op_write;
  logic [7:0]      r_addr;
  logic [7:0]      r_tx_data;
  logic            r_tx_call;
  logic            r_wr_strobe;
  logic            r_frame_ok;
  logic [7:0]      r_err_cnt;
  logic [TW-1:0]   r_tmo_cnt;
  logic [7:0]      r_regs [N_REG];

  logic            w_timed;
  logic            w_timeout;
  logic            w_err_inc;
  logic            w_wr_en;
  logic            w_frame_done;
  logic            w_tx_set;
  logic [7:0]      w_tx_val;
  logic            w_tx_clear;
  logic            w_call_set;
  logic            w_op_latch;
  logic            w_addr_latch;
  logic [7:0]      w_rd_val;

  // Chip select crosses in asynchronously; reset to deselected.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ncs_meta <= 1'b1;
      r_ncs_sync <= 1'b1;
    end else begin
      r_ncs_meta <= ncs;
      r_ncs_sync <= r_ncs_meta;
    end
  end

  always_comb begin
    w_rd_val = 8'h00;
    for (int k = 0; k < N_REG; k++) begin
      if (rx_data == 8'(k)) w_rd_val = r_regs[k];
    end
  end

  assign w_timed   = (r_state == GET_ADDR) || (r_state == GET_DATA) || (r_state == TX_WAIT);
  assign w_timeout = w_timed && (r_tmo_cnt == TMO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  // Priority: chip-select abort, then byte/tx events, then timeout.
  always_comb begin
    w_state_next = r_state;
    w_err_inc    = 1'b0;
    w_wr_en      = 1'b0;
    w_frame_done = 1'b0;
    w_tx_set     = 1'b0;
    w_tx_val     = 8'h00;
    w_tx_clear   = 1'b0;
    w_call_set   = 1'b0;
    w_op_latch   = 1'b0;
    w_addr_latch = 1'b0;
    if ((r_state != IDLE) && r_ncs_sync) begin
      w_state_next = IDLE;
      w_tx_clear   = 1'b1;
      w_err_inc    = (r_state == GET_ADDR) || (r_state == GET_DATA);
    end else begin
      case (r_state)
        IDLE: begin
          if (rx_done) begin
            case (rx_data)
              CMD_STATUS: begin
                w_tx_set     = 1'b1;
                w_tx_val     = STATUS_BYTE;
                w_state_next = TX_LOAD;
              end
              CMD_ID: begin
                w_tx_set     = 1'b1;
                w_tx_val     = ID_BYTE;
                w_state_next = TX_LOAD;
              end
              CMD_WRITE, CMD_READ: begin
                w_op_latch   = 1'b1;
                w_state_next = GET_ADDR;
              end
              default: w_err_inc = 1'b1;
            endcase
          end
        end
        GET_ADDR: begin
          if (rx_done) begin
            w_addr_latch = 1'b1;
            if (r_op_write) begin
              w_state_next = GET_DATA;
            end else begin
              w_tx_set     = 1'b1;
              w_tx_val     = w_rd_val;
              w_err_inc    = (rx_data >= N_REG_B);
              w_state_next = TX_LOAD;
            end
          end else if (w_timeout) begin
            w_err_inc    = 1'b1;
            w_state_next = IDLE;
          end
        end
        GET_DATA: begin
          if (rx_done) begin
            if (r_addr < N_REG_B) begin
              w_wr_en      = 1'b1;
              w_frame_done = 1'b1;
            end else begin
              w_err_inc = 1'b1;
            end
            w_state_next = IDLE;
          end else if (w_timeout) begin
            w_err_inc    = 1'b1;
            w_state_next = IDLE;
          end
        end
        TX_LOAD: begin
          w_call_set   = 1'b1;
          w_state_next = TX_WAIT;
        end
        TX_WAIT: begin
          if (tx_done) begin
            w_tx_clear   = 1'b1;
            w_frame_done = 1'b1;
            w_state_next = IDLE;
          end else if (w_timeout) begin
            w_tx_clear   = 1'b1;
            w_err_inc    = 1'b1;
            w_state_next = IDLE;
          end
        end
        default: w_state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op_write  <= 1'b0;
      r_addr      <= 8'h00;
      r_tx_data   <= 8'h00;
      r_tx_call   <= 1'b0;
      r_wr_strobe <= 1'b0;
      r_frame_ok  <= 1'b0;
      r_err_cnt   <= 8'h00;
      r_tmo_cnt   <= '0;
    end else begin
      r_wr_strobe <= w_wr_en;
      r_frame_ok  <= w_frame_done;
      if (w_op_latch)   r_op_write <= (rx_data == CMD_WRITE);
      if (w_addr_latch) r_addr     <= rx_data;
      if (w_tx_clear)    r_tx_data <= 8'h00;
      else if (w_tx_set) r_tx_data <= w_tx_val;
      if (w_tx_clear)      r_tx_call <= 1'b0;
      else if (w_call_set) r_tx_call <= 1'b1;
      if (w_err_inc && (r_err_cnt != 8'hFF)) r_err_cnt <= r_err_cnt + 8'd1;
      if (!w_timed || rx_done || tx_done || w_timeout) r_tmo_cnt <= '0;
      else                                             r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N_REG; k++) r_regs[k] <= REG_RST;
    end else begin
      for (int k = 0; k < N_REG; k++) begin
        if (w_wr_en && (r_addr == 8'(k))) r_regs[k] <= rx_data;
      end
    end
  end

  for (genvar g = 0; g < N_REG; g++) begin : g_pos
    assign servo_pos[8*g +: 8] = r_regs[g];
  end

  assign tx_call   = r_tx_call;
  assign tx_data   = r_tx_data;
  assign wr_strobe = r_wr_strobe;
  assign frame_ok  = r_frame_ok;
  assign err_cnt   = r_err_cnt;
  assign o_state   = r_state;

endmodule
